// File: rtl/set_assoc_read_cache.sv
// N-way set-associative, read-only, word-addressed cache with blocking misses.
// A request is looked up one cycle after acceptance. A miss fetches a whole line
// from memory, fills a victim way and then answers the request. A flush walks the
// sets one per cycle and clears the valid bits and replacement pointers.
module set_assoc_read_cache #(
    parameter int unsigned NrWays    = 2,
    parameter int unsigned NrSets    = 64,
    parameter int unsigned LineWords = 4
) (
    input  logic                      clk_i,
    input  logic                      resetn_i,
    input  logic [31:0]               addr_i,
    input  logic                      read_en_i,
    output logic                      ready_o,
    output logic                      read_valid_o,
    output logic [31:0]               read_word_o,
    input  logic                      flush_i,
    output logic [31:0]               mem_addr_o,
    output logic                      mem_read_en_o,
    input  logic                      mem_read_valid_i,
    input  logic [32*LineWords-1:0]   mem_read_data_i,
    output logic [31:0]               hit_count_o,
    output logic [31:0]               miss_count_o
);

    localparam int unsigned OffsetBits = $clog2(LineWords * 4);
    localparam int unsigned IndexBits  = $clog2(NrSets);
    localparam int unsigned TagBits    = 32 - IndexBits - OffsetBits;
    localparam int unsigned WordBits   = $clog2(LineWords);
    localparam int unsigned WayBits    = (NrWays > 1) ? $clog2(NrWays) : 1;
    localparam int unsigned LineBits   = 32 * LineWords;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StRefill,
        StRespond,
        StFlush
    } state_e;

    state_e state_q, state_d;

    // Bits [1:0] of the byte address never select anything.
    logic [31:2]          reqAddr_q, reqAddr_d;
    logic [31:0]          memAddr_q, memAddr_d;
    logic                 readValid_q, readValid_d;
    logic [31:0]          readWord_q, readWord_d;
    logic [31:0]          hitCount_q, hitCount_d;
    logic [31:0]          missCount_q, missCount_d;
    logic [IndexBits-1:0] flushIdx_q, flushIdx_d;
    logic                 unusedAddrBits;

    // Cache storage: valid bits and round-robin pointers are reset, payload is not.
    logic [NrWays-1:0]    valid_q [NrSets];
    logic [WayBits-1:0]   rr_q    [NrSets];
    logic [TagBits-1:0]   tag_q   [NrWays][NrSets];
    logic [LineBits-1:0]  data_q  [NrWays][NrSets];

    logic [TagBits-1:0]   reqTag;
    logic [IndexBits-1:0] reqIndex;
    logic [WordBits-1:0]  reqWord;
    logic                 lookupHit;
    logic [WayBits-1:0]   hitWay;
    logic [WayBits-1:0]   victimWay;
    logic                 victimUsesPtr;
    logic [WayBits-1:0]   nextPtr;
    logic [LineBits-1:0]  hitLine;
    logic                 refillWe;

    assign unusedAddrBits = ^addr_i[1:0];

    assign reqTag   = reqAddr_q[31 -: TagBits];
    assign reqIndex = reqAddr_q[OffsetBits +: IndexBits];
    assign reqWord  = reqAddr_q[2 +: WordBits];

    assign ready_o       = (state_q == StIdle);
    assign read_valid_o  = readValid_q;
    assign read_word_o   = readWord_q;
    assign mem_addr_o    = memAddr_q;
    assign mem_read_en_o = (state_q == StRefill);
    assign hit_count_o   = hitCount_q;
    assign miss_count_o  = missCount_q;

    // Tag match across the ways of the requested set; descending scan lets the lowest way win.
    always_comb begin
        lookupHit = 1'b0;
        hitWay    = '0;
        for (int w = NrWays - 1; w >= 0; w--) begin
            if (valid_q[reqIndex][w] && (tag_q[w][reqIndex] == reqTag)) begin
                lookupHit = 1'b1;
                hitWay    = WayBits'(w);
            end
        end
        hitLine = data_q[hitWay][reqIndex];
    end

    // Victim choice: lowest invalid way, otherwise the set's round-robin pointer.
    always_comb begin
        victimUsesPtr = 1'b1;
        victimWay     = rr_q[reqIndex];
        for (int w = NrWays - 1; w >= 0; w--) begin
            if (!valid_q[reqIndex][w]) begin
                victimUsesPtr = 1'b0;
                victimWay     = WayBits'(w);
            end
        end
        nextPtr = (rr_q[reqIndex] == WayBits'(NrWays - 1)) ? '0 : rr_q[reqIndex] + 1'b1;
    end

    // Controller next-state, request capture, response data and counters.
    always_comb begin
        state_d     = state_q;
        reqAddr_d   = reqAddr_q;
        memAddr_d   = memAddr_q;
        readValid_d = 1'b0;
        readWord_d  = readWord_q;
        hitCount_d  = hitCount_q;
        missCount_d = missCount_q;
        flushIdx_d  = flushIdx_q;
        refillWe    = 1'b0;
        case (state_q)
            StIdle: begin
                if (flush_i) begin
                    flushIdx_d = '0;
                    state_d    = StFlush;
                end else if (read_en_i) begin
                    reqAddr_d = addr_i[31:2];
                    state_d   = StLookup;
                end
            end
            StLookup: begin
                if (lookupHit) begin
                    readValid_d = 1'b1;
                    readWord_d  = hitLine[{reqWord, 5'b0} +: 32];
                    hitCount_d  = (hitCount_q == '1) ? hitCount_q : hitCount_q + 32'd1;
                    state_d     = StIdle;
                end else begin
                    missCount_d = (missCount_q == '1) ? missCount_q : missCount_q + 32'd1;
                    memAddr_d   = {reqTag, reqIndex, {OffsetBits{1'b0}}};
                    state_d     = StRefill;
                end
            end
            StRefill: begin
                if (mem_read_valid_i) begin
                    refillWe    = 1'b1;
                    readValid_d = 1'b1;
                    readWord_d  = mem_read_data_i[{reqWord, 5'b0} +: 32];
                    state_d     = StRespond;
                end
            end
            StRespond: begin
                state_d = StIdle;
            end
            StFlush: begin
                if (flushIdx_q == IndexBits'(NrSets - 1)) begin
                    state_d = StIdle;
                end else begin
                    flushIdx_d = flushIdx_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Controller registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q     <= StIdle;
            reqAddr_q   <= '0;
            memAddr_q   <= '0;
            readValid_q <= 1'b0;
            readWord_q  <= '0;
            hitCount_q  <= '0;
            missCount_q <= '0;
            flushIdx_q  <= '0;
        end else begin
            state_q     <= state_d;
            reqAddr_q   <= reqAddr_d;
            memAddr_q   <= memAddr_d;
            readValid_q <= readValid_d;
            readWord_q  <= readWord_d;
            hitCount_q  <= hitCount_d;
            missCount_q <= missCount_d;
            flushIdx_q  <= flushIdx_d;
        end
    end

    // Valid bits and replacement pointers: cleared by reset or flush, set by refills.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            for (int s = 0; s < NrSets; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else if (state_q == StFlush) begin
            valid_q[flushIdx_q] <= '0;
            rr_q[flushIdx_q]    <= '0;
        end else if (refillWe) begin
            valid_q[reqIndex][victimWay] <= 1'b1;
            if (victimUsesPtr) begin
                rr_q[reqIndex] <= nextPtr;
            end
        end
    end

    // Line payload and tag written into the victim way when refill data arrives.
    always_ff @(posedge clk_i) begin
        if (refillWe) begin
            data_q[victimWay][reqIndex] <= mem_read_data_i;
            tag_q[victimWay][reqIndex]  <= reqTag;
        end
    end

endmodule

// File: tb/tb_set_assoc_read_cache.sv
// Directed bench for set_assoc_read_cache (2 ways, 64 sets, 4-word lines).
// A table of reads with hand-computed hit/miss, word and latency, followed by
// hand-written flush, reset-during-refill and counter saturation sequences.
module tb_set_assoc_read_cache;

    logic         clk_i;
    logic         resetn_i;
    logic [31:0]  addr_i;
    logic         read_en_i;
    logic         ready_o;
    logic         read_valid_o;
    logic [31:0]  read_word_o;
    logic         flush_i;
    logic [31:0]  mem_addr_o;
    logic         mem_read_en_o;
    logic         mem_read_valid_i;
    logic [127:0] mem_read_data_i;
    logic [31:0]  hit_count_o;
    logic [31:0]  miss_count_o;

    int checks;
    int failures;
    int expHits;
    int expMisses;

    typedef struct {
        logic [31:0] addr;
        int          waitCycles;
        bit          expHit;
        logic [31:0] expWord;
    } vec_t;

    set_assoc_read_cache #(
        .NrWays(2),
        .NrSets(64),
        .LineWords(4)
    ) dut (
        .clk_i(clk_i),
        .resetn_i(resetn_i),
        .addr_i(addr_i),
        .read_en_i(read_en_i),
        .ready_o(ready_o),
        .read_valid_o(read_valid_o),
        .read_word_o(read_word_o),
        .flush_i(flush_i),
        .mem_addr_o(mem_addr_o),
        .mem_read_en_o(mem_read_en_o),
        .mem_read_valid_i(mem_read_valid_i),
        .mem_read_data_i(mem_read_data_i),
        .hit_count_o(hit_count_o),
        .miss_count_o(miss_count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Memory contents: line 0x1000 holds A,B,C,D; others are derived from the line address.
    function automatic logic [31:0] memWord(input logic [31:0] lineAddr, input int w);
        if (lineAddr == 32'h0000_1000) return 32'hA + 32'(w);
        return lineAddr + 32'h5000_0000 + 32'(w);
    endfunction

    function automatic logic [127:0] memLine(input logic [31:0] lineAddr);
        logic [127:0] line;
        for (int w = 0; w < 4; w++) line[32*w +: 32] = memWord(lineAddr, w);
        return line;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
        end
    endtask

    task automatic checkCounters(input string tag);
        checkOutput({tag, " hit_count"}, hit_count_o, 32'(expHits));
        checkOutput({tag, " miss_count"}, miss_count_o, 32'(expMisses));
    endtask

    // Issue one read and serve any refill after waitCycles cycles of mem_read_en_o.
    task automatic applyStimulus(input logic [31:0] addr, input int waitCycles,
                                 output logic [31:0] word, output int latency, output bit sawMem);
        int          memCycles;
        bit          done;
        logic [31:0] expLine;
        expLine   = {addr[31:4], 4'b0};
        word      = '0;
        latency   = -1;
        sawMem    = 1'b0;
        memCycles = 0;
        done      = 1'b0;
        @(negedge clk_i);
        addr_i    = addr;
        read_en_i = 1'b1;
        @(posedge clk_i);
        #1;
        read_en_i = 1'b0;
        for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
            @(negedge clk_i);
            mem_read_valid_i = 1'b0;
            if (read_valid_o) begin
                word    = read_word_o;
                latency = cyc;
                done    = 1'b1;
            end else if (mem_read_en_o) begin
                sawMem = 1'b1;
                checkOutput("mem_addr", mem_addr_o, expLine);
                if (memCycles == waitCycles) begin
                    mem_read_valid_i = 1'b1;
                    mem_read_data_i  = memLine(expLine);
                end
                memCycles++;
            end
        end
        mem_read_valid_i = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("[TB] FAIL read timeout addr=%h: no read_valid_o within 60 cycles", addr);
        end
    endtask

    // Read, then check word, hit/miss, latency, pulse width and counters.
    task automatic doRead(input string name, input logic [31:0] addr, input int waitCycles,
                          input bit expHit, input logic [31:0] expWord);
        logic [31:0] word;
        int          latency;
        bit          sawMem;
        applyStimulus(addr, waitCycles, word, latency, sawMem);
        if (expHit) expHits++;
        else        expMisses++;
        checkOutput({name, " word"}, word, expWord);
        checkOutput({name, " mem request"}, 32'(sawMem), expHit ? 32'd0 : 32'd1);
        checkOutput({name, " latency"}, 32'(latency), expHit ? 32'd2 : 32'(3 + waitCycles));
        @(negedge clk_i);
        checkOutput({name, " valid pulse"}, 32'(read_valid_o), 32'd0);
        checkCounters(name);
    endtask

    vec_t vecs[12];
    int   lowCycles;
    bit   badActivity;
    int   pulses;

    initial begin
        checks           = 0;
        failures         = 0;
        expHits          = 0;
        expMisses        = 0;
        resetn_i         = 1'b0;
        addr_i           = '0;
        read_en_i        = 1'b0;
        flush_i          = 1'b0;
        mem_read_valid_i = 1'b0;
        mem_read_data_i  = '0;

        // Set 0 holds A=0x1000, B=0x11000, C=0x21000; ways fill 0,1 then round-robin from 0.
        vecs[0]  = '{32'h0000_1004, 4, 1'b0, 32'hB};
        vecs[1]  = '{32'h0000_100C, 0, 1'b1, 32'hD};
        vecs[2]  = '{32'h0001_1000, 1, 1'b0, 32'h5001_1000};
        vecs[3]  = '{32'h0000_1000, 0, 1'b1, 32'hA};
        vecs[4]  = '{32'h0001_1004, 0, 1'b1, 32'h5001_1001};
        vecs[5]  = '{32'h0000_1008, 0, 1'b1, 32'hC};
        vecs[6]  = '{32'h0002_1000, 0, 1'b0, 32'h5002_1000};
        vecs[7]  = '{32'h0000_1000, 2, 1'b0, 32'hA};
        vecs[8]  = '{32'h0002_100C, 0, 1'b1, 32'h5002_1003};
        vecs[9]  = '{32'h0001_1000, 0, 1'b0, 32'h5001_1000};
        vecs[10] = '{32'h0000_1004, 0, 1'b1, 32'hB};
        vecs[11] = '{32'h0002_1000, 0, 1'b0, 32'h5002_1000};

        repeat (3) @(negedge clk_i);
        checkOutput("reset ready", 32'(ready_o), 32'd1);
        checkOutput("reset read_valid", 32'(read_valid_o), 32'd0);
        checkOutput("reset read_word", read_word_o, 32'd0);
        checkOutput("reset mem_read_en", 32'(mem_read_en_o), 32'd0);
        checkOutput("reset mem_addr", mem_addr_o, 32'd0);
        checkCounters("reset");
        resetn_i = 1'b1;

        for (int i = 0; i < 12; i++) begin
            doRead($sformatf("vec%0d", i), vecs[i].addr, vecs[i].waitCycles, vecs[i].expHit, vecs[i].expWord);
        end

        // Flush: fill three sets, confirm hits, then flush together with a read.
        doRead("fill0", 32'h0000_4040, 0, 1'b0, 32'h5000_4040);
        doRead("fill1", 32'h0000_4054, 1, 1'b0, 32'h5000_4051);
        doRead("fill2", 32'h0000_5068, 0, 1'b0, 32'h5000_5062);
        doRead("prehit", 32'h0000_4044, 0, 1'b1, 32'h5000_4041);
        @(negedge clk_i);
        flush_i   = 1'b1;
        read_en_i = 1'b1;
        addr_i    = 32'h0000_4040;
        @(posedge clk_i);
        #1;
        flush_i   = 1'b0;
        read_en_i = 1'b0;
        lowCycles   = 0;
        badActivity = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk_i);
            if (read_valid_o || mem_read_en_o) badActivity = 1'b1;
            if (ready_o) break;
            lowCycles++;
        end
        checkOutput("flush busy cycles", 32'(lowCycles), 32'd64);
        checkOutput("flush dropped read", 32'(badActivity), 32'd0);
        checkCounters("flush");
        doRead("postflush0", 32'h0000_4040, 0, 1'b0, 32'h5000_4040);
        doRead("postflush1", 32'h0000_4054, 0, 1'b0, 32'h5000_4051);
        doRead("postflush2", 32'h0000_5068, 0, 1'b0, 32'h5000_5062);

        // Reset in the middle of a refill; a late memory response must be ignored.
        @(negedge clk_i);
        addr_i    = 32'h0000_6070;
        read_en_i = 1'b1;
        @(posedge clk_i);
        #1;
        read_en_i = 1'b0;
        for (int cyc = 0; cyc < 10 && !mem_read_en_o; cyc++) @(negedge clk_i);
        checkOutput("refill started", 32'(mem_read_en_o), 32'd1);
        @(negedge clk_i);
        resetn_i = 1'b0;
        #1;
        expHits   = 0;
        expMisses = 0;
        checkOutput("mid-refill reset mem_read_en", 32'(mem_read_en_o), 32'd0);
        checkOutput("mid-refill reset ready", 32'(ready_o), 32'd1);
        checkOutput("mid-refill reset mem_addr", mem_addr_o, 32'd0);
        checkCounters("mid-refill reset");
        @(negedge clk_i);
        resetn_i = 1'b1;
        @(negedge clk_i);
        mem_read_valid_i = 1'b1;
        mem_read_data_i  = memLine(32'h0000_6070);
        pulses = 0;
        @(negedge clk_i);
        mem_read_valid_i = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            if (read_valid_o || mem_read_en_o) pulses++;
            @(negedge clk_i);
        end
        checkOutput("late mem valid ignored", 32'(pulses), 32'd0);
        doRead("after reset", 32'h0000_6074, 1, 1'b0, 32'h5000_6071);

        // Miss counter saturation from a preloaded value.
        @(negedge clk_i);
        force dut.missCount_q = 32'hFFFF_FFFE;
        @(negedge clk_i);
        release dut.missCount_q;
        @(negedge clk_i);
        checkOutput("preload miss_count", miss_count_o, 32'hFFFF_FFFE);
        begin
            logic [31:0] word;
            int          latency;
            bit          sawMem;
            applyStimulus(32'h0000_7080, 0, word, latency, sawMem);
            checkOutput("sat miss1 word", word, 32'h5000_7080);
            checkOutput("sat miss1 count", miss_count_o, 32'hFFFF_FFFF);
            applyStimulus(32'h0000_8084, 0, word, latency, sawMem);
            checkOutput("sat miss2 word", word, 32'h5000_8081);
            checkOutput("sat miss2 count", miss_count_o, 32'hFFFF_FFFF);
            checkOutput("sat hit_count", hit_count_o, 32'(expHits));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
